sigmoid_pipe: RTL and testbench
===============================

SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 7: signed two's-complement input width per lane.
REQ-002 SHALL have parameter OUT_W, default 7: unsigned output width per lane.
REQ-003 SHALL have parameter LANES, default 4: number of parallel channels.
REQ-004 SHALL have parameter ADDR_W, default 5: LUT index width; depth = 2^ADDR_W; ADDR_W < IN_W.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: input beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data, input, LANES*IN_W: lane k occupies bits [k*IN_W +: IN_W].
REQ-010 SHALL have port out_valid, output, 1: output beat valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the beat.
REQ-012 SHALL have port out_data, output, LANES*OUT_W: lane k occupies bits [k*OUT_W +: OUT_W].
REQ-013 SHALL have port cfg_req, input, 1: request LUT load mode.
REQ-014 SHALL have port cfg_ack, output, 1: load mode active; writes are permitted.
REQ-015 SHALL have ports cfg_we (input, 1), cfg_addr (input, ADDR_W) and cfg_data (input, OUT_W): LUT write port.
REQ-016 SHALL have port busy, output, 1: high whenever any pipeline stage holds valid data.

Function
REQ-017 SHALL map each lane to LUT index idx = top ADDR_W bits of {~in[IN_W-1], in[IN_W-2:0]} (offset binary), so -2^(IN_W-1) maps to 0 and 0 maps to 2^(ADDR_W-1).
REQ-018 SHALL, without interpolation, output lut[idx] per lane; all lanes share one LUT, read concurrently.
REQ-019 SHALL have a latency of 2 cycles from accept to out_valid: stage 1 registers the index (and fraction), stage 2 registers the LUT result.
REQ-020 SHALL define adv = !out_valid || out_ready; all stages advance together only when adv is high.
REQ-021 SHALL drive in_ready = adv && (state == RUN), sustaining one beat per cycle with no bubbles under continuous out_ready.
REQ-022 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL implement a three-state FSM: RUN, DRAIN, LOAD.
REQ-024 SHALL transition from RUN to DRAIN when cfg_req=1; in_ready=0 from that cycle on.
REQ-025 SHALL transition from DRAIN to LOAD when busy=0; if cfg_req drops during DRAIN, it SHALL return to RUN.
REQ-026 SHALL assert cfg_ack only in LOAD; cfg_we with cfg_ack=1 writes lut[cfg_addr] = cfg_data, and cfg_we with cfg_ack=0 is ignored.
REQ-027 SHALL transition from LOAD to RUN when cfg_req=0; a write in that same cycle still commits.
REQ-028 SHALL make a write visible to the first beat accepted after LOAD exits.

Reset
REQ-029 SHALL, while rst=1, clear out_valid, all stage valids, busy and cfg_ack to 0, zero out_data, set state to RUN and clear all LUT entries to 0.
REQ-030 SHALL discard in-flight beats when rst is asserted mid-stream or mid-load; no partial output.

Configuration
REQ-031 SHALL use macro SIGMOID_PIPE_INTERP_EN to control interpolation.
REQ-032 SHALL, when SIGMOID_PIPE_INTERP_EN is defined: use F = IN_W-ADDR_W low bits as frac; output lut[idx] + ((lut[idx+1]-lut[idx])*frac >> F), signed difference, with no wrap; for idx = max, output lut[idx]; add one stage, giving latency 3.
REQ-033 SHALL, when SIGMOID_PIPE_INTERP_EN is undefined, have no multiplier and latency 2.

Structure
REQ-034 SHALL place the FSM state enum (RUN/DRAIN/LOAD) and default widths in shared package sigmoid_pkg.
REQ-035 SHALL use one sub-module, sigmoid_lane: per-lane index/fraction extraction and optional interpolation, instantiated LANES times.

Verification
REQ-036 SHALL cover: load lut[i]=i, send lanes {0, -64, 63, -1} -> out {16, 0, 31, 15} after 2 cycles.
REQ-037 SHALL cover: 20 back-to-back beats with out_ready=1 -> 20 outputs on consecutive cycles, in order.
REQ-038 SHALL cover: out_ready=0 for 5 cycles mid-stream -> out_data held, in_ready=0, no loss or duplication.
REQ-039 SHALL cover: cfg_req asserted with 2 beats in flight -> cfg_ack rises only after both outputs drain; writes before cfg_ack are ignored.
REQ-040 SHALL cover: rst pulsed mid-stream -> out_valid=0 next cycle, LUT reads return 0.
REQ-041 SHALL cover, with INTERP_EN: lut[i]=4*i, input 2 -> out 66 with latency 3; input 63 -> 124.

Source files
------------

// File: rtl/sigmoid_pkg.sv
// Shared state encoding, default widths and pipeline depth for the sigmoid LUT pipeline.
// SIGMOID_PIPE_INTERP_EN selects the interpolating (3-stage) datapath.
package sigmoid_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int DEF_IN_W   = 7;
    localparam int DEF_OUT_W  = 7;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADDR_W = 5;

`ifdef SIGMOID_PIPE_INTERP_EN
    localparam int PIPE_LAT = 3;
`else
    localparam int PIPE_LAT = 2;
`endif

endpackage

// File: rtl/sigmoid_lane.sv
// One lane: offset-binary index/fraction extraction, LUT result register, optional interpolation.
// Latency 2 (3 with SIGMOID_PIPE_INTERP_EN); registers move only when adv is high, else they hold.
// Backpressure comes entirely from the shared adv strobe supplied by sigmoid_pipe.
module sigmoid_lane
    import sigmoid_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [IN_W-1:0]   lane_in,
    output logic [ADDR_W-1:0] idx_q,
    input  logic [OUT_W-1:0]  lut_lo,
`ifdef SIGMOID_PIPE_INTERP_EN
    input  logic [OUT_W-1:0]  lut_hi,
`endif
    output logic [OUT_W-1:0]  lane_out
);

    localparam int F = IN_W - ADDR_W;

    // Flipping the sign bit turns two's complement into offset binary, so the
    // most negative input lands on entry 0 and zero on the table midpoint.
    logic [IN_W-1:0] ofs;
    assign ofs = {~lane_in[IN_W-1], lane_in[IN_W-2:0]};

`ifdef SIGMOID_PIPE_INTERP_EN
    localparam int PW = OUT_W + F + 2;

    logic [F-1:0]          frac_q;
    logic [F-1:0]          frac_q2;
    logic [OUT_W-1:0]      lo_q;
    logic [OUT_W-1:0]      hi_q;
    logic signed [OUT_W:0] diff;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  sum;
    logic [F+1:0]          unused_sum;

    // The step lies between lo and hi, so the sum never leaves the output range.
    assign diff       = $signed({1'b0, hi_q}) - $signed({1'b0, lo_q});
    assign prod       = PW'(diff) * PW'($signed({1'b0, frac_q2}));
    assign sum        = PW'($signed({1'b0, lo_q})) + (prod >>> F);
    assign unused_sum = sum[PW-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            frac_q   <= '0;
            frac_q2  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            lane_out <= '0;
        end else if (adv) begin
            idx_q    <= ofs[IN_W-1 -: ADDR_W];
            frac_q   <= ofs[F-1:0];
            lo_q     <= lut_lo;
            hi_q     <= (&idx_q) ? lut_lo : lut_hi;
            frac_q2  <= frac_q;
            lane_out <= sum[OUT_W-1:0];
        end
    end
`else
    logic [F-1:0] unused_frac;
    assign unused_frac = ofs[F-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            lane_out <= '0;
        end else if (adv) begin
            idx_q    <= ofs[IN_W-1 -: ADDR_W];
            lane_out <= lut_lo;
        end
    end
`endif

endmodule

// File: rtl/sigmoid_pipe.sv
// Multi-lane sigmoid via a shared, run-time loadable LUT; SIGMOID_PIPE_INTERP_EN adds linear interpolation.
// Latency 2 cycles accept-to-out_valid (3 with SIGMOID_PIPE_INTERP_EN), one beat per cycle sustained.
// All stages stall together while out_valid && !out_ready; loads drain the pipe before cfg_ack rises.
module sigmoid_pipe
    import sigmoid_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    input  logic                   cfg_req,
    output logic                   cfg_ack,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [OUT_W-1:0]       cfg_data,
    output logic                   busy
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t              state;
    logic [OUT_W-1:0]    lut [DEPTH];
    logic [PIPE_LAT-1:0] vld;
    logic                adv;

    assign out_valid = vld[PIPE_LAT-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && (state == RUN);
    assign busy      = |vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[PIPE_LAT-2:0], in_valid && in_ready};
        end
    end

    // cfg_ack is registered alongside the state so it is high exactly in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cfg_ack <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (cfg_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!cfg_req) begin
                        state <= RUN;
                    end else if (!busy) begin
                        state   <= LOAD;
                        cfg_ack <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!cfg_req) begin
                        state   <= RUN;
                        cfg_ack <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    cfg_ack <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
        end else if (cfg_we && cfg_ack) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ADDR_W-1:0] idx_q;
`ifdef SIGMOID_PIPE_INTERP_EN
        logic [ADDR_W-1:0] idx_nx;
        assign idx_nx = idx_q + ADDR_W'(1);
`endif

        sigmoid_lane #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .lane_in  (in_data[k*IN_W +: IN_W]),
            .idx_q    (idx_q),
            .lut_lo   (lut[idx_q]),
`ifdef SIGMOID_PIPE_INTERP_EN
            .lut_hi   (lut[idx_nx]),
`endif
            .lane_out (out_data[k*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Randomized bench for sigmoid_pipe against an arithmetic LUT model and an in-order scoreboard.
// Define SIGMOID_PIPE_INTERP_EN for both bench and RTL to exercise the interpolating build.
module tb_sigmoid_pipe;

    localparam int IN_W   = 7;
    localparam int OUT_W  = 7;
    localparam int LANES  = 4;
    localparam int ADDR_W = 5;
    localparam int F      = IN_W - ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DW     = LANES * IN_W;
    localparam int OW     = LANES * OUT_W;
`ifdef SIGMOID_PIPE_INTERP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              cfg_req;
    logic              cfg_ack;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [OUT_W-1:0]  cfg_data;
    logic              busy;

    sigmoid_pipe #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_req   (cfg_req),
        .cfg_ack   (cfg_ack),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_out  = 0;
    int            mlut [DEPTH];
    logic [OW-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Sigmoid table lookup expressed as plain integer arithmetic on the lane value.
    function automatic logic [OW-1:0] model(input logic [DW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            logic signed [IN_W-1:0] s;
            int u, idx, v;
            s   = d[k*IN_W +: IN_W];
            u   = int'(s) + 2**(IN_W-1);
            idx = u / 2**F;
            v   = mlut[idx];
`ifdef SIGMOID_PIPE_INTERP_EN
            if (idx < DEPTH-1) begin
                int fr;
                fr = u % 2**F;
                v  = mlut[idx] + (((mlut[idx+1] - mlut[idx]) * fr) >>> F);
            end
`endif
            r[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        return r;
    endfunction

    // Monitor: records accepted beats, checks outputs in order and stability under stall.
    initial begin
        logic          prev_stall;
        logic [OW-1:0] prev_dat;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_vld", out_valid, 1);
                    chk("hold_dat", out_data, prev_dat);
                end
                if (in_valid && in_ready) sb.push_back(model(in_data));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("spurious_out", out_valid, 0);
                    else begin
                        chk("out_dat", out_data, sb.pop_front());
                        n_out++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_dat   = out_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk(tag, out_valid, 1);
    endtask

    // mode 0: lut[i]=i, 1: lut[i]=4*i, 2: random. Entry 'skip' is left untouched.
    // The final write shares its cycle with the cfg_req drop.
    task automatic load_lut(input int mode, input int skip);
        int t;
        int v;
        cfg_req = 1'b1;
        t = 0;
        while (!cfg_ack && t < 64) begin
            tick();
            t++;
        end
        chk("ack_rise", cfg_ack, 1);
        for (int i = 0; i < DEPTH; i++) begin
            v = (mode == 0) ? i : (mode == 1) ? 4 * i : int'($urandom_range(0, 2**OUT_W - 1));
            if (i != skip) begin
                cfg_we   = 1'b1;
                cfg_addr = ADDR_W'(i);
                cfg_data = OUT_W'(v);
                if (cfg_ack) mlut[i] = v;
            end else begin
                cfg_we = 1'b0;
            end
            if (i == DEPTH-1) cfg_req = 1'b0;
            tick();
        end
        cfg_we = 1'b0;
        chk("ack_fall", cfg_ack, 0);
    endtask

    initial begin
        logic [OW-1:0] exp_v;
        int            n0;
        int            t;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        for (int i = 0; i < DEPTH; i++) mlut[i] = 0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        // Directed known-answer beat and latency.
`ifdef SIGMOID_PIPE_INTERP_EN
        load_lut(1, -1);
        in_data = {7'h00, 7'h00, 7'h3F, 7'h02};
        exp_v   = {7'd64, 7'd64, 7'd124, 7'd66};
`else
        load_lut(0, -1);
        in_data = {7'h7F, 7'h3F, 7'h40, 7'h00};
        exp_v   = {7'd15, 7'd31, 7'd0, 7'd16};
`endif
        in_valid = 1'b1;
        chk("dir_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            chk("dir_lat_early", out_valid, 0);
            tick();
        end
        chk("dir_lat", out_valid, 1);
        chk("dir_out", out_data, exp_v);
        tick();

        // 20 back-to-back beats must come out on 20 consecutive cycles.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    in_data  = DW'($urandom);
                    in_valid = 1'b1;
                    chk("b2b_in_ready", in_ready, 1);
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 20; i++) begin
                    chk("b2b_out_valid", out_valid, 1);
                    @(negedge clk);
                end
            end
        join
        repeat (3) tick();
        chk("b2b_count", n_out - n0, 20);

        // Five-cycle downstream stall with a full pipe.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (3) begin
            in_data = DW'($urandom);
            tick();
        end
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", in_ready, 0);
            in_data = DW'($urandom);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (6) tick();
        chk("stall_sb_empty", sb.size(), 0);

        // Load request with two beats in flight; early writes must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        tick();
        in_data   = DW'($urandom);
        tick();
        in_valid = 1'b0;
        cfg_req  = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(5);
        cfg_data = 7'd99;
        chk("drain_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_no_ack", cfg_ack, 0);
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (!cfg_ack && t < 20) begin
            tick();
            t++;
        end
        chk("drain_ack", cfg_ack, 1);
        chk("drain_idle", busy, 0);
        chk("drain_sb_empty", sb.size(), 0);
        load_lut(2, 5);
        in_data  = {LANES{7'h54}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("probe_out_valid");
        chk("drain_write_ignored", out_data[OUT_W-1:0], mlut[5]);
        tick();

        // Random traffic with random backpressure on the freshly loaded table.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("rand_sb_empty", sb.size(), 0);

        // Reset mid-stream: in-flight beats vanish and the table reads back zero.
        in_valid = 1'b1;
        repeat (2) begin
            in_data = DW'($urandom);
            tick();
        end
        out_ready = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mlut[i] = 0;
        out_ready = 1'b1;
        in_data   = DW'($urandom);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("post_rst_out_valid");
        chk("post_rst_lut_zero", out_data, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
